fetch_stage: RTL and testbench

//  Instruction-fetch stage. Owns the PC, drives the address of the byte-addressed,
//  1-cycle-latency synchronous instruction memory (imem), and presents
//  {pc, instruction} to decode over a valid/ready handshake.

---
 rtl/fetch_stage.sv | 78 +++++++
 tb/tb_fetch_stage.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/fetch_stage.sv
`default_nettype none
// ============================================================================
// Module  : fetch_stage
// Brief   : Instruction fetch. Owns the PC, addresses a 1-cycle imem and
//           presents {pc, ins} to decode over valid/ready with replay/redirect.
// Revision: 1.0 - initial release
// ============================================================================
module fetch_stage #(
    parameter int              XLEN      = 32,
    parameter int              IMEM_SIZE = 1024,
    parameter int              ADDR_BITS = $clog2(IMEM_SIZE),
    parameter logic [XLEN-1:0] RESET_PC  = '0,
    parameter logic [XLEN-1:0] NOP_INS   = XLEN'(32'h0000_0013)
) (
    input  logic                 clk,
    input  logic                 reset,
    output logic [ADDR_BITS-1:0] imem_addr,
    input  logic [XLEN-1:0]      imem_ins,
    input  logic                 redirect_valid,
    input  logic [XLEN-1:0]      redirect_pc,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [XLEN-1:0]      out_pc,
    output logic [XLEN-1:0]      out_ins,
    output logic                 out_fault,
    output logic [31:0]          fetch_count
);

    localparam logic [XLEN-1:0] c_LAST_PC = XLEN'(IMEM_SIZE - 4);
    localparam logic [XLEN-1:0] c_PC_STEP = XLEN'(4);

    logic            r_rsp_valid;
    logic [XLEN-1:0] r_rsp_pc;
    logic [31:0]     r_fetch_count;
    logic [XLEN-1:0] w_req_pc;
    logic            w_out_valid;
    logic            w_bad_pc;

    // Stalling re-issues the held address so imem keeps returning the same word.
    always_comb begin
        w_req_pc = RESET_PC;
        if (reset) begin
            w_req_pc = RESET_PC;
        end else if (redirect_valid) begin
            w_req_pc = redirect_pc;
        end else if (r_rsp_valid && !out_ready) begin
            w_req_pc = r_rsp_pc;
        end else if (r_rsp_valid) begin
            w_req_pc = r_rsp_pc + c_PC_STEP;
        end
    end

    assign imem_addr   = w_req_pc[ADDR_BITS-1:0];
    assign w_out_valid = r_rsp_valid && !redirect_valid && !reset;
    assign w_bad_pc    = (r_rsp_pc[1:0] != 2'b00) || (r_rsp_pc > c_LAST_PC);

    assign out_valid   = w_out_valid;
    assign out_pc      = r_rsp_pc;
    assign out_fault   = w_out_valid && w_bad_pc;
    assign out_ins     = out_fault ? NOP_INS : imem_ins;
    assign fetch_count = r_fetch_count;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_rsp_valid   <= 1'b0;
            r_rsp_pc      <= RESET_PC;
            r_fetch_count <= 32'd0;
        end else begin
            r_rsp_valid <= 1'b1;
            r_rsp_pc    <= w_req_pc;
            if (w_out_valid && out_ready) begin
                r_fetch_count <= r_fetch_count + 32'd1;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_fetch_stage.sv
`default_nettype none
// ============================================================================
// Module  : tb_fetch_stage
// Brief   : Self-checking bench for fetch_stage: directed cycle table plus
//           randomized ready/redirect/reset against a reference PC model.
// Revision: 1.0 - initial release
// ============================================================================
module tb_fetch_stage;

    localparam logic [31:0] c_NOP = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [9:0]  imem_addr;
    logic [31:0] imem_ins = '0;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = '0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [31:0] out_pc;
    logic [31:0] out_ins;
    logic        out_fault;
    logic [31:0] fetch_count;

    fetch_stage dut (
        .clk            (clk),
        .reset          (reset),
        .imem_addr      (imem_addr),
        .imem_ins       (imem_ins),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_pc         (out_pc),
        .out_ins        (out_ins),
        .out_fault      (out_fault),
        .fetch_count    (fetch_count)
    );

    always #5 clk = ~clk;

    logic [31:0] mem [256];
    always @(posedge clk) imem_ins <= mem[imem_addr[9:2]];

    typedef struct {
        logic        rst, rdy, rv;
        logic [31:0] rpc;
        logic        e_valid;
        logic [31:0] e_pc, e_ins;
        logic        e_fault;
        logic [9:0]  e_addr;
        logic [31:0] e_cnt;
    } vec_t;

    typedef struct {
        logic [31:0] pc, ins;
        logic        fault;
    } exp_t;

    vec_t        tbl[$];
    exp_t        sb[$];
    int          n_chk = 0;
    int          n_err = 0;
    int          cyc   = 0;
    logic        m_valid = 1'b0;
    logic [31:0] m_pc    = '0;
    logic [31:0] m_count = '0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s cycle %0d: got %h expected %h", nm, cyc, act, exp);
        end
    endtask

    function automatic exp_t mk_exp(input logic [31:0] pc);
        exp_t e;
        e.pc    = pc;
        e.fault = (pc[1:0] != 2'b00) || (pc > 32'd1020);
        e.ins   = e.fault ? c_NOP : mem[pc[9:2]];
        return e;
    endfunction

    // One cycle: drive, check presented outputs against the reference, advance model.
    task automatic step(input logic rst_i, input logic rdy, input logic rv, input logic [31:0] rpc);
        logic [31:0] req;
        logic        m_out_valid;
        exp_t        e;
        @(negedge clk);
        reset = rst_i; out_ready = rdy; redirect_valid = rv; redirect_pc = rpc;
        #1;
        cyc++;
        m_out_valid = m_valid && !rv && !rst_i;
        chk("out_valid", {31'd0, out_valid}, {31'd0, m_out_valid});
        chk("fetch_count", fetch_count, m_count);
        if (sb.size() > 0) begin
            e = sb.pop_front();
            if (m_out_valid) begin
                chk("sb_pc", out_pc, e.pc);
                chk("sb_ins", out_ins, e.ins);
                chk("sb_fault", {31'd0, out_fault}, {31'd0, e.fault});
            end
        end else if (m_out_valid) begin
            chk("sb_underflow", 32'd0, 32'd1);
        end
        if (!m_out_valid) chk("fault_idle", {31'd0, out_fault}, 32'd0);
        if (rst_i)                 req = 32'd0;
        else if (rv)               req = rpc;
        else if (m_valid && !rdy)  req = m_pc;
        else if (m_valid)          req = m_pc + 32'd4;
        else                       req = 32'd0;
        chk("imem_addr", {22'd0, imem_addr}, {22'd0, req[9:0]});
        if (rst_i) begin
            m_valid = 1'b0; m_pc = '0; m_count = '0;
            sb.delete();
        end else begin
            if (m_out_valid && rdy) m_count = m_count + 32'd1;
            m_valid = 1'b1;
            m_pc    = req;
            sb.push_back(mk_exp(req));
        end
    endtask

    function automatic vec_t v(input logic rst, rdy, rv, input logic [31:0] rpc,
                               input logic ev, input logic [31:0] epc, eins,
                               input logic ef, input logic [9:0] ea, input logic [31:0] ec);
        vec_t t;
        t.rst = rst; t.rdy = rdy; t.rv = rv; t.rpc = rpc;
        t.e_valid = ev; t.e_pc = epc; t.e_ins = eins; t.e_fault = ef;
        t.e_addr = ea; t.e_cnt = ec;
        return t;
    endfunction

    initial begin
        logic        r_rst, r_rdy, r_rv;
        logic [31:0] r_pc;
        for (int i = 0; i < 256; i++) mem[i] = 32'h0A00_0000 | 32'(i);
        mem[0] = 32'h6700_0F0F; mem[1] = 32'hB700_00F0;
        mem[2] = 32'h3300_0000; mem[3] = 32'h3301_1000;

        // Reset, streaming, first fetch_count checkpoint
        tbl.push_back(v(1,1,0,0,      0,0,0,0,0,0));
        tbl.push_back(v(1,1,0,0,      0,0,0,0,0,0));
        tbl.push_back(v(0,1,0,0,      0,0,0,0,0,0));
        tbl.push_back(v(0,1,0,0,      1,0,32'h6700_0F0F,0,4,0));
        tbl.push_back(v(0,1,0,0,      1,4,32'hB700_00F0,0,8,1));
        tbl.push_back(v(0,1,0,0,      1,8,32'h3300_0000,0,12,2));
        tbl.push_back(v(0,1,0,0,      1,12,32'h3301_1000,0,16,3));
        tbl.push_back(v(0,1,0,0,      1,16,32'h0A00_0004,0,20,4));
        // Stall at pc 4 for three cycles, then release
        tbl.push_back(v(0,1,1,4,      0,0,0,0,4,5));
        tbl.push_back(v(0,0,0,0,      1,4,32'hB700_00F0,0,4,5));
        tbl.push_back(v(0,0,0,0,      1,4,32'hB700_00F0,0,4,5));
        tbl.push_back(v(0,0,0,0,      1,4,32'hB700_00F0,0,4,5));
        tbl.push_back(v(0,1,0,0,      1,4,32'hB700_00F0,0,8,5));
        tbl.push_back(v(0,1,0,0,      1,8,32'h3300_0000,0,12,6));
        // Redirect to 12 while stalled at 4
        tbl.push_back(v(0,1,1,4,      0,0,0,0,4,7));
        tbl.push_back(v(0,0,0,0,      1,4,32'hB700_00F0,0,4,7));
        tbl.push_back(v(0,0,1,12,     0,0,0,0,12,7));
        tbl.push_back(v(0,1,0,0,      1,12,32'h3301_1000,0,16,7));
        tbl.push_back(v(0,1,0,0,      1,16,32'h0A00_0004,0,20,8));
        // Faults: misaligned, out of range, last valid word
        tbl.push_back(v(0,1,1,6,      0,0,0,0,6,9));
        tbl.push_back(v(0,1,0,0,      1,6,c_NOP,1,10,9));
        tbl.push_back(v(0,1,0,0,      1,10,c_NOP,1,14,10));
        tbl.push_back(v(0,1,1,32'h400,0,0,0,0,0,11));
        tbl.push_back(v(0,1,0,0,      1,32'h400,c_NOP,1,4,11));
        tbl.push_back(v(0,1,0,0,      1,32'h404,c_NOP,1,8,12));
        tbl.push_back(v(0,1,1,32'h3FC,0,0,0,0,10'h3FC,13));
        tbl.push_back(v(0,1,0,0,      1,32'h3FC,32'h0A00_00FF,0,0,13));
        tbl.push_back(v(0,1,0,0,      1,32'h400,c_NOP,1,4,14));
        // Reset mid-stream while stalled
        tbl.push_back(v(0,0,0,0,      1,32'h404,c_NOP,1,4,15));
        tbl.push_back(v(1,0,0,0,      0,0,0,0,0,15));
        tbl.push_back(v(0,1,0,0,      0,0,0,0,0,0));
        tbl.push_back(v(0,1,0,0,      1,0,32'h6700_0F0F,0,4,0));

        foreach (tbl[i]) begin
            step(tbl[i].rst, tbl[i].rdy, tbl[i].rv, tbl[i].rpc);
            chk("tbl_valid", {31'd0, out_valid}, {31'd0, tbl[i].e_valid});
            chk("tbl_fault", {31'd0, out_fault}, {31'd0, tbl[i].e_fault});
            chk("tbl_addr", {22'd0, imem_addr}, {22'd0, tbl[i].e_addr});
            chk("tbl_count", fetch_count, tbl[i].e_cnt);
            if (tbl[i].e_valid) begin
                chk("tbl_pc", out_pc, tbl[i].e_pc);
                chk("tbl_ins", out_ins, tbl[i].e_ins);
            end
        end

        // Randomized ready/redirect/reset traffic including PC wrap
        for (int i = 0; i < 600; i++) begin
            r_rst = ($urandom_range(0, 99) == 0);
            r_rdy = ($urandom_range(0, 9) < 7);
            r_rv  = ($urandom_range(0, 7) == 0);
            case ($urandom_range(0, 4))
                0:       r_pc = {22'd0, 8'($urandom_range(0, 255)), 2'b00};
                1:       r_pc = $urandom;
                2:       r_pc = 32'h0000_03FC;
                3:       r_pc = 32'hFFFF_FFFC;
                default: r_pc = 32'($urandom_range(0, 1023));
            endcase
            step(r_rst, r_rdy, r_rv, r_pc);
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
`default_nettype wire
